// File: rtl/state_xfer_pkg.sv
// Shared definitions for the state transfer unit: FSM encoding, transfer
// direction codes and amplitude field boundaries.
package state_xfer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_STORE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        STORE = ST_STORE,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } xfer_state_e;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

    // Amplitude layout: {real[REAL_MSB:IMAG_MSB+1], imag[IMAG_MSB:0]}
    localparam int REAL_MSB = 63;
    localparam int IMAG_MSB = 31;

endpackage

// File: rtl/state_xfer_unit_if.sv
// Stream and LDM bus bundle of the state transfer unit; master is the unit,
// slave is the HBM stream / PE array side.
interface state_xfer_unit_if #(
    parameter int GADDR_W = 18,
    parameter int DW      = 64,
    parameter int PE_NUM  = 4
) ();
    logic                 i_s_valid;
    logic [DW-1:0]        i_s_data;
    logic                 o_s_ready;
    logic                 o_m_valid;
    logic [DW-1:0]        o_m_data;
    logic                 o_m_last;
    logic                 i_m_ready;
    logic [GADDR_W-1:0]   o_ldm_addr;
    logic [DW-1:0]        o_ldm_data;
    logic                 o_ldm_en;
    logic                 o_ldm_we;
    logic [PE_NUM*DW-1:0] i_ldm_rdata;

    modport master (
        input  i_s_valid, i_s_data, i_m_ready, i_ldm_rdata,
        output o_s_ready, o_m_valid, o_m_data, o_m_last,
               o_ldm_addr, o_ldm_data, o_ldm_en, o_ldm_we
    );

    modport slave (
        output i_s_valid, i_s_data, i_m_ready, i_ldm_rdata,
        input  o_s_ready, o_m_valid, o_m_data, o_m_last,
               o_ldm_addr, o_ldm_data, o_ldm_en, o_ldm_we
    );
endinterface

// File: rtl/state_xfer_unit_skid_fifo.sv
// xfer_skid_fifo: 2-entry valid/ready FIFO holding {last, data} for the
// STORE output stream; the writer guarantees space via occ_o.
module xfer_skid_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_ready_i,
    output logic         head_valid_o,
    output logic [W-1:0] head_data_o,
    output logic [1:0]   occ_o
);

    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign head_valid_o = (cnt_q != 2'd0);
    assign do_pop       = head_valid_o & pop_ready_i;
    assign do_push      = push_valid_i & ((cnt_q != 2'd2) | do_pop);
    assign occ_o        = cnt_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ent
            logic [W-1:0] ent_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_q <= '0;
                end else if (do_push && (wr_ptr_q == 1'(gi))) begin
                    ent_q <= push_data_i;
                end
            end
        end
    endgenerate

    assign head_data_o = rd_ptr_q ? g_ent[1].ent_q : g_ent[0].ent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/state_xfer_unit.sv
// Moves state-vector amplitudes between the HBM stream and the PE LDMs.
// Optional STATE_XFER_CHECKSUM_EN adds an XOR checksum of transferred words.
module state_xfer_unit
    import state_xfer_pkg::*;
#(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int GADDR_W          = PE_NUM_WIDTH + STATE_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_dir,
    input  logic [GADDR_W-1:0]   i_base,
    input  logic [GADDR_W:0]     i_len,
    state_xfer_unit_if.master    bus,
    output logic                 o_busy,
    output logic                 o_done_state_transfer
`ifdef STATE_XFER_CHECKSUM_EN
    ,
    output logic [STATE_DATA_WIDTH-1:0] o_checksum
`endif
);

    localparam int DW = STATE_DATA_WIDTH;

    xfer_state_e               state_q;
    logic [GADDR_W-1:0]        cur_q;
    logic [GADDR_W:0]          rem_q;
    logic                      s_ready_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      rd_inflight_q;
    logic                      rd_last_q;
    logic [PE_NUM_WIDTH-1:0]   rd_pe_q;

    logic                      load_hs;
    logic                      rd_issue;
    logic                      last_beat;
    logic                      m_pop;
    logic                      fifo_valid;
    logic [DW:0]               fifo_head;
    logic [1:0]                fifo_occ;
    logic [2:0]                rd_budget;
    logic [DW-1:0]             rd_slice [PE_NUM];

    generate
        for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_slice
            assign rd_slice[gi] = bus.i_ldm_rdata[gi*DW +: DW];
        end
    endgenerate

    assign load_hs   = s_ready_q & bus.i_s_valid;
    assign m_pop     = fifo_valid & bus.i_m_ready;
    assign last_beat = (rem_q == (GADDR_W+1)'(1));

    // A pop in this cycle frees a slot, so counting it keeps reads back-to-back
    // under continuous ready without ever overrunning the two FIFO entries.
    assign rd_budget = {1'b0, fifo_occ} + {2'b00, rd_inflight_q} - {2'b00, m_pop};
    assign rd_issue  = (state_q == STORE) && (rd_budget < 3'd2);

    assign bus.o_s_ready  = s_ready_q;
    assign bus.o_ldm_en   = load_hs | rd_issue;
    assign bus.o_ldm_we   = load_hs;
    assign bus.o_ldm_addr = (load_hs | rd_issue) ? cur_q : '0;
    assign bus.o_ldm_data = load_hs ? bus.i_s_data : '0;
    assign bus.o_m_valid  = fifo_valid;
    assign bus.o_m_data   = fifo_valid ? fifo_head[DW-1:0] : '0;
    assign bus.o_m_last   = fifo_valid & fifo_head[DW];

    assign o_busy                = busy_q;
    assign o_done_state_transfer = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            rem_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        cur_q  <= i_base;
                        rem_q  <= i_len;
                        busy_q <= 1'b1;
                        if (i_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (i_dir == DIR_STORE) begin
                            state_q <= STORE;
                        end else begin
                            state_q   <= LOAD;
                            s_ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        cur_q <= cur_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (last_beat) begin
                            s_ready_q <= 1'b0;
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                        end
                    end
                end
                STORE: begin
                    if (rd_issue) begin
                        cur_q <= cur_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (last_beat) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The tagged final beat leaving means nothing is left queued or in flight.
                    if (m_pop && fifo_head[DW]) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_pe_q       <= '0;
        end else begin
            rd_inflight_q <= rd_issue;
            rd_last_q     <= rd_issue & last_beat;
            rd_pe_q       <= cur_q[GADDR_W-1 -: PE_NUM_WIDTH];
        end
    end

    xfer_skid_fifo #(
        .W(DW + 1)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (rd_inflight_q),
        .push_data_i  ({rd_last_q, rd_slice[rd_pe_q]}),
        .pop_ready_i  (bus.i_m_ready),
        .head_valid_o (fifo_valid),
        .head_data_o  (fifo_head),
        .occ_o        (fifo_occ)
    );

`ifdef STATE_XFER_CHECKSUM_EN
    logic [DW-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (state_q == IDLE && i_start) begin
            csum_q <= '0;
        end else if (load_hs) begin
            csum_q <= csum_q ^ bus.i_s_data;
        end else if (m_pop) begin
            csum_q <= csum_q ^ fifo_head[DW-1:0];
        end
    end

    assign o_checksum = csum_q;
`endif

endmodule

// File: tb/tb_state_xfer_unit.sv
// Self-checking bench for state_xfer_unit: table of transfers with a
// scoreboard of expected LDM writes / store beats, plus reset and len=0 cases.
module tb_state_xfer_unit;
    import state_xfer_pkg::*;

    localparam int PW = 2;
    localparam int PN = 4;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int GW = PW + AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [GW-1:0] base = '0;
    logic [GW:0]   len = '0;
    logic          busy;
    logic          done;
`ifdef STATE_XFER_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    always #5 clk = ~clk;

    state_xfer_unit_if #(.GADDR_W(GW), .DW(DW), .PE_NUM(PN)) bus ();

    state_xfer_unit #(
        .PE_NUM_WIDTH(PW), .PE_NUM(PN), .STATE_ADDR_WIDTH(AW),
        .STATE_DATA_WIDTH(DW), .GADDR_W(GW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_start               (start),
        .i_dir                 (dir),
        .i_base                (base),
        .i_len                 (len),
        .bus                   (bus),
        .o_busy                (busy),
        .o_done_state_transfer (done)
`ifdef STATE_XFER_CHECKSUM_EN
        ,
        .o_checksum            (csum)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Cycle counter and LDM read model: addressed PE returns global addr + 0x100.
    int cyc = 0;
    logic [PN*DW-1:0] rdata_q = '0;
    assign bus.i_ldm_rdata = rdata_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.o_ldm_en && !bus.o_ldm_we) begin
            for (int k = 0; k < PN; k++) begin
                rdata_q[k*DW +: DW] <= (k == int'(bus.o_ldm_addr[GW-1 -: PW]))
                    ? (64'(bus.o_ldm_addr) + 64'h100)
                    : (64'hBAD0_0000_0000_0000 + 64'(k));
            end
        end
    end

    typedef struct { logic [GW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [DW-1:0] data; logic last; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];
    wr_t wr_e;

    int done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int first_beat_cyc = -1, last_beat_cyc = 0;
    int en_cnt = 0, rd_issue_cnt = 0, issued = 0, accepted = 0;

    // Scoreboard monitor, sampling mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.o_ldm_en) en_cnt++;
                if (bus.o_ldm_en && bus.o_ldm_we) begin
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                    last_beat_cyc = cyc;
                    last_hs_cyc   = cyc;
                    if (wr_q.size() == 0) begin
                        check("ldm_write_unexpected", 64'd1, 64'd0);
                    end else begin
                        wr_e = wr_q.pop_front();
                        check("ldm_addr", 64'(bus.o_ldm_addr), 64'(wr_e.addr));
                        check("ldm_data", bus.o_ldm_data, wr_e.data);
                    end
                end
                if (bus.o_ldm_en && !bus.o_ldm_we) begin
                    issued++;
                    rd_issue_cnt++;
                end
                if (bus.o_m_valid) begin
                    if (rd_q.size() == 0) begin
                        check("m_valid_unexpected", 64'd1, 64'd0);
                    end else begin
                        check("m_data", bus.o_m_data, rd_q[0].data);
                        check("m_last", 64'(bus.o_m_last), 64'(rd_q[0].last));
                        if (bus.i_m_ready) begin
                            if (first_beat_cyc < 0) first_beat_cyc = cyc;
                            last_beat_cyc = cyc;
                            if (bus.o_m_last) last_hs_cyc = cyc;
                            void'(rd_q.pop_front());
                            accepted++;
                        end
                    end
                end
                if (bus.o_ldm_en && !bus.o_ldm_we)
                    check("reads_outstanding_le2", 64'((issued - accepted) <= 2), 64'd1);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    typedef struct {
        logic          dir;
        logic [GW-1:0] base;
        int            len;
        logic [DW-1:0] dbase;
        bit            toggle;
        bit            glitch;
    } row_t;

    task automatic run_row(input row_t r, input int idx);
        logic [GW-1:0] a;
        logic [DW-1:0] xs;
        int d0, r0, to, i, k;
        bit hs;
        xs = '0;
        d0 = done_cnt;
        r0 = rd_issue_cnt;
        first_beat_cyc = -1;
        for (int j = 0; j < r.len; j++) begin
            a = r.base + GW'(j);
            if (r.dir == DIR_LOAD) begin
                wr_q.push_back('{a, r.dbase + 64'(j)});
                xs = xs ^ (r.dbase + 64'(j));
            end else begin
                rd_q.push_back('{64'(a) + 64'h100, (j == r.len - 1)});
                xs = xs ^ (64'(a) + 64'h100);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; dir = r.dir; base = r.base; len = (GW+1)'(r.len);
        if (r.dir == DIR_LOAD) begin
            bus.i_s_valid = 1'b1;
            bus.i_s_data  = r.dbase;
        end
        @(posedge clk); #1;
        start = 1'b0;
        to = 0;
        if (r.dir == DIR_LOAD) begin
            i = 0;
            while (i < r.len && to < 100) begin
                if (r.glitch && i == 1) begin
                    start = 1'b1; dir = DIR_STORE; len = (GW+1)'(2);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                hs = bus.o_s_ready;
                @(posedge clk); #1;
                to++;
                if (hs) begin
                    i++;
                    bus.i_s_data = r.dbase + 64'(i);
                end
            end
            bus.i_s_valid = 1'b0;
            start = 1'b0;
        end else begin
            k = 0;
            while (done_cnt == d0 && to < 200) begin
                bus.i_m_ready = r.toggle ? (k % 3 == 0) : 1'b1;
                @(posedge clk); #1;
                k++;
                to++;
            end
            bus.i_m_ready = 1'b1;
        end
        to = 0;
        while (done_cnt == d0 && to < 20) begin
            @(posedge clk); #1;
            to++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check("done_latency", 64'(done_cyc - last_hs_cyc), 64'd1);
        if (!r.toggle)
            check("beats_consecutive", 64'(last_beat_cyc - first_beat_cyc), 64'(r.len - 1));
        repeat (3) @(posedge clk);
        #1;
        check("single_done", 64'(done_cnt - d0), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("queue_drained", 64'(wr_q.size() + rd_q.size()), 64'd0);
        if (r.glitch) check("no_reads_in_load", 64'(rd_issue_cnt - r0), 64'd0);
`ifdef STATE_XFER_CHECKSUM_EN
        check("checksum", csum, xs);
`endif
        $display("xfer %0d dir=%0d base=0x%0h len=%0d toggle=%0d glitch=%0d finished at cycle %0d",
                 idx, r.dir, r.base, r.len, r.toggle, r.glitch, cyc);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_done"},      64'(done), 64'd0);
        check({tag, "_s_ready"},   64'(bus.o_s_ready), 64'd0);
        check({tag, "_m_valid"},   64'(bus.o_m_valid), 64'd0);
        check({tag, "_m_data"},    bus.o_m_data, 64'd0);
        check({tag, "_m_last"},    64'(bus.o_m_last), 64'd0);
        check({tag, "_ldm_en"},    64'(bus.o_ldm_en), 64'd0);
        check({tag, "_ldm_we"},    64'(bus.o_ldm_we), 64'd0);
        check({tag, "_ldm_addr"},  64'(bus.o_ldm_addr), 64'd0);
        check({tag, "_ldm_data"},  bus.o_ldm_data, 64'd0);
    endtask

    row_t rows[5];

    initial begin
        int d0, e0, a0, sc, to;
        rows[0] = '{DIR_LOAD,  18'h00010,          4, 64'hA,                   1'b0, 1'b0};
        rows[1] = '{DIR_STORE, {2'd2, 16'h0005},   3, 64'h0,                   1'b0, 1'b0};
        rows[2] = '{DIR_STORE, 18'h1FFFC,          8, 64'h0,                   1'b1, 1'b0};
        rows[3] = '{DIR_LOAD,  18'h3FFFE,          4, 64'hCAFE_F00D_0000_0100, 1'b0, 1'b0};
        rows[4] = '{DIR_LOAD,  18'h21000,          4, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1};

        bus.i_s_valid = 1'b0;
        bus.i_s_data  = '0;
        bus.i_m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef STATE_XFER_CHECKSUM_EN
        check("reset_checksum", csum, 64'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int n = 0; n < 5; n++) run_row(rows[n], n);

        // Zero-length transfer: done pulse without any LDM activity.
        d0 = done_cnt;
        e0 = en_cnt;
        @(posedge clk); #1;
        start = 1'b1; dir = DIR_LOAD; len = '0; base = 18'h00100;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        to = 0;
        while (done_cnt == d0 && to < 5) begin
            @(posedge clk); #1;
            to++;
        end
        check("len0_done_seen", 64'(done_cnt - d0), 64'd1);
        check("len0_done_latency_ok", 64'((done_cyc - sc) >= 1 && (done_cyc - sc) <= 2), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("len0_no_en", 64'(en_cnt - e0), 64'd0);
        check("len0_busy_after", 64'(busy), 64'd0);
        $display("xfer len0 finished at cycle %0d", cyc);

        // Reset in the middle of a 6-beat STORE.
        d0 = done_cnt;
        a0 = accepted;
        for (int j = 0; j < 6; j++)
            rd_q.push_back('{64'(18'h30000 + j) + 64'h100, (j == 5)});
        @(posedge clk); #1;
        start = 1'b1; dir = DIR_STORE; base = 18'h30000; len = (GW+1)'(6);
        @(posedge clk); #1;
        start = 1'b0;
        to = 0;
        while ((accepted - a0) < 2 && to < 50) begin
            @(posedge clk); #1;
            to++;
        end
        check("rst_two_beats_seen", 64'(accepted - a0), 64'd2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
`ifdef STATE_XFER_CHECKSUM_EN
        check("midrst_checksum", csum, 64'd0);
`endif
        rd_q.delete();
        issued = 0;
        accepted = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_busy_low", 64'(busy), 64'd0);
        $display("xfer reset-abort finished at cycle %0d", cyc);

        run_row('{DIR_LOAD, 18'h2ABCD, 1, 64'h5555_AAAA_0F0F_F0F0, 1'b0, 1'b0}, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
